// File: rtl/hazard_unit_pkg.sv
// Shared encodings for the pipeline hazard controller.
package hazard_unit_pkg;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_LOAD_STALL = 2'd1,
        ST_STORE_WAIT = 2'd2,
        ST_FLUSH      = 2'd3
    } state_t;

    // Operand-mux select that picks the forwarding bus.
    localparam logic [1:0] MODE_FWD = 2'b11;

    // Forwarding source selects.
    localparam logic FWD_MEM = 1'b0;
    localparam logic FWD_WB  = 1'b1;

endpackage

// File: rtl/hazard_fwd_cmp.sv
// Per-operand forwarding comparator and priority mux; also flags a load-use match.
module hazard_fwd_cmp
    import hazard_unit_pkg::*;
#(
    parameter int REG_AW   = 5,
    parameter int ZERO_REG = 1
) (
    input  logic [REG_AW-1:0] src,
    input  logic              src_valid,
    input  logic [REG_AW-1:0] mem_dst,
    input  logic              mem_wen,
    input  logic              mem_is_load,
    input  logic [REG_AW-1:0] wb_dst,
    input  logic              wb_wen,
    input  logic [1:0]        mode_in,
    output logic [1:0]        mode_out,
    output logic              fwd_sel,
    output logic              load_use
);

    logic live;

    // MEM result is the youngest, so it beats WB; a load in MEM has no value yet and stalls instead.
    always_comb begin
        live     = src_valid && !((ZERO_REG != 0) && (src == '0));
        mode_out = mode_in;
        fwd_sel  = FWD_MEM;
        load_use = live && mem_wen && mem_is_load && (src == mem_dst);
        if (live && mem_wen && !mem_is_load && (src == mem_dst)) begin
            mode_out = MODE_FWD;
            fwd_sel  = FWD_MEM;
        end else if (live && wb_wen && (src == wb_dst)) begin
            mode_out = MODE_FWD;
            fwd_sel  = FWD_WB;
        end
    end

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard controller: operand forwarding, load-use stall, store wait
// with timeout, branch flush, and saturating stall/flush performance counters.
module hazard_unit
    import hazard_unit_pkg::*;
#(
    parameter int REG_AW        = 5,
    parameter int NUM_SRC       = 2,
    parameter int FLUSH_CYCLES  = 2,
    parameter int STORE_TIMEOUT = 15,
    parameter int CNT_W         = 16,
    parameter int ZERO_REG      = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_SRC*REG_AW-1:0] ex_src,
    input  logic [NUM_SRC-1:0]        ex_src_valid,
    input  logic [REG_AW-1:0]         mem_dst,
    input  logic                      mem_wen,
    input  logic                      mem_is_load,
    input  logic [REG_AW-1:0]         wb_dst,
    input  logic                      wb_wen,
    input  logic [NUM_SRC*2-1:0]      mode_in,
    output logic [NUM_SRC*2-1:0]      mode_out,
    output logic [NUM_SRC-1:0]        fwd_sel,
    input  logic                      store_req,
    input  logic                      ram_ack,
    output logic                      ram_sel,
    input  logic                      branch_taken,
    output logic                      stall,
    output logic                      flush,
    output logic                      store_err,
    output logic [CNT_W-1:0]          stall_cnt,
    output logic [CNT_W-1:0]          flush_cnt
);

    localparam int FLUSH_W = $clog2(FLUSH_CYCLES + 1);
    localparam int TO_W    = $clog2(STORE_TIMEOUT + 1);

    logic [NUM_SRC-1:0] load_use_vec;
    logic               load_use;

    state_t             state_q, state_d;
    logic [FLUSH_W-1:0] flush_ctr_q, flush_ctr_d;
    logic [TO_W-1:0]    to_q, to_d;
    logic [TO_W-1:0]    to_inc;
    logic               stall_q, stall_d;
    logic               flush_q, flush_d;
    logic               ram_sel_q, ram_sel_d;
    logic               err_q, err_d;
    logic               flush_entry;
    logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]   flush_cnt_q, flush_cnt_d;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_SRC; gi++) begin : g_fwd
            hazard_fwd_cmp #(
                .REG_AW   (REG_AW),
                .ZERO_REG (ZERO_REG)
            ) u_cmp (
                .src         (ex_src[gi*REG_AW +: REG_AW]),
                .src_valid   (ex_src_valid[gi]),
                .mem_dst     (mem_dst),
                .mem_wen     (mem_wen),
                .mem_is_load (mem_is_load),
                .wb_dst      (wb_dst),
                .wb_wen      (wb_wen),
                .mode_in     (mode_in[gi*2 +: 2]),
                .mode_out    (mode_out[gi*2 +: 2]),
                .fwd_sel     (fwd_sel[gi]),
                .load_use    (load_use_vec[gi])
            );
        end
    endgenerate

    assign load_use = |load_use_vec;

    // Next-state and next-output logic; outputs are registered so they reflect the state entered.
    always_comb begin
        state_d     = state_q;
        flush_ctr_d = flush_ctr_q;
        to_d        = to_q;
        to_inc      = to_q + TO_W'(1);
        stall_d     = 1'b0;
        flush_d     = 1'b0;
        ram_sel_d   = 1'b0;
        err_d       = err_q;
        flush_entry = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (branch_taken) begin
                    state_d     = ST_FLUSH;
                    flush_ctr_d = FLUSH_W'(FLUSH_CYCLES - 1);
                    flush_d     = 1'b1;
                    flush_entry = 1'b1;
                end else if (store_req) begin
                    state_d   = ST_STORE_WAIT;
                    to_d      = '0;
                    stall_d   = 1'b1;
                    ram_sel_d = 1'b1;
                end else if (load_use) begin
                    state_d = ST_LOAD_STALL;
                    stall_d = 1'b1;
                end
            end
            ST_LOAD_STALL: begin
                state_d = ST_IDLE;
            end
            ST_STORE_WAIT: begin
                // An ack on the final allowed cycle still counts as success.
                if (ram_ack) begin
                    state_d = ST_IDLE;
                end else if (to_inc == TO_W'(STORE_TIMEOUT)) begin
                    to_d    = to_inc;
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    to_d      = to_inc;
                    stall_d   = 1'b1;
                    ram_sel_d = 1'b1;
                end
            end
            ST_FLUSH: begin
                // A new taken branch restarts the flush window.
                if (branch_taken) begin
                    flush_ctr_d = FLUSH_W'(FLUSH_CYCLES - 1);
                    flush_d     = 1'b1;
                    flush_entry = 1'b1;
                end else if (flush_ctr_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    flush_ctr_d = flush_ctr_q - FLUSH_W'(1);
                    flush_d     = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        stall_cnt_d = (stall_q && !(&stall_cnt_q)) ? stall_cnt_q + CNT_W'(1) : stall_cnt_q;
        flush_cnt_d = (flush_entry && !(&flush_cnt_q)) ? flush_cnt_q + CNT_W'(1) : flush_cnt_q;
    end

    // Single state/output register bank; async reset returns everything to idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            flush_ctr_q <= '0;
            to_q        <= '0;
            stall_q     <= 1'b0;
            flush_q     <= 1'b0;
            ram_sel_q   <= 1'b0;
            err_q       <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            flush_ctr_q <= flush_ctr_d;
            to_q        <= to_d;
            stall_q     <= stall_d;
            flush_q     <= flush_d;
            ram_sel_q   <= ram_sel_d;
            err_q       <= err_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall     = stall_q;
    assign flush     = flush_q;
    assign ram_sel   = ram_sel_q;
    assign store_err = err_q;
    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule
